boot_loader: RTL and testbench
==============================

Name: boot_loader

Overview:
- Sequencer that loads a program image into the byte-wide external code/data memory before the multicycle MIPS core runs.
- Holds the core in reset and owns the memory write port while loading.
- Receives a length-prefixed, checksummed byte stream over a valid/ready handshake and writes it to consecutive addresses.
- After a good checksum it hands the memory port to the core and releases core reset.

Parameters:
- WIDTH, 8, memory address/data width, matching the core's WIDTH.
- BASE, 0, first memory address written; WIDTH bits.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load.
- rx_data  in  8  stream byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts rx_data this cycle.
- cpu_memwrite  in  1  core write strobe.
- cpu_adr  in  WIDTH  core address.
- cpu_writedata  in  WIDTH  core write data.
- mem_memwrite  out  1  to memory.
- mem_adr  out  WIDTH  to memory.
- mem_writedata  out  WIDTH  to memory.
- cpureset  out  1  active-high synchronous reset to the core.
- done  out  1  image loaded and checksum good.
- error  out  1  checksum mismatch.
- count  out  8  data bytes written in the current load.

Behaviour:
- Transfer: a byte transfers on a rising edge when rx_valid & rx_ready. rx_data must not be sampled otherwise. Held rx_valid while rx_ready=0 is not consumed.
- rx_ready=1 only in states LEN, DATA and CSUM.
- Stream format: length byte L (0..255), then L data bytes, then checksum byte C = sum of the data bytes mod 256.
- State IDLE: reset state. start -> LEN.
- State LEN: on transfer, latch L, clear idx and sum. If L=0 -> CSUM, else -> DATA.
- State DATA: on transfer, latch byte into wbuf, sum += byte (mod 256) -> WRITE.
- State WRITE (one cycle):
  - mem_memwrite=1, mem_adr = BASE+idx (mod 2^WIDTH), mem_writedata = zero-extended/truncated wbuf.
  - idx += 1.
  - If idx+1 == L -> CSUM, else -> DATA.
- State CSUM: on transfer, if byte == sum -> RUN, else -> ERROR.
- State RUN: done=1, cpureset=0. Memory outputs pass through cpu_memwrite, cpu_adr, cpu_writedata unchanged (combinational). start -> LEN.
- State ERROR: error=1, cpureset=1. start -> LEN.
- Port ownership:
  - In every state except RUN, cpu_* inputs are ignored.
  - In all non-RUN states, mem_adr = BASE+idx and mem_writedata = wbuf.
  - mem_memwrite is 1 only in WRITE and RUN (pass-through).
- Throughput: at most one data byte per 2 cycles. Exactly one mem_memwrite pulse per data byte.
- Outputs are decoded from registered state/regs; no combinational path from rx_valid to rx_ready.
- cpureset:
  - 1 in all states except RUN.
  - Goes 0 on the edge entering RUN.
  - Returns to 1 on the edge leaving RUN, so the core restarts from PC 0 after a reload.
- done/error are cleared on entry to LEN.
- count = idx. Reset value 0; cleared on entry to LEN.
- start in LEN, DATA, WRITE or CSUM is ignored. start in IDLE, RUN or ERROR is always honoured. start together with a valid byte in those states: the byte is not consumed (rx_ready=0 that cycle).
- Address wrap: BASE+idx wraps modulo 2^WIDTH. The loader does not check for overrun.
- Reset (reset=0 at an edge), including mid-load:
  - state=IDLE, rx_ready=0, mem_memwrite=0, cpureset=1, done=0, error=0, count=0, wbuf=0, sum=0.
  - Bytes already written stay in memory.
- Bytes arriving after C while in RUN/ERROR are not consumed.

Test Plan:
- Normal load, BASE=0:
  - Stimulus: start; stream 03,80,04,11,95.
  - Required: three single-cycle writes, (adr,data) = (0,80),(1,04),(2,11); then done=1, error=0, count=3.
  - cpureset=0 starting the cycle after C is accepted, and cpu_* is mirrored onto mem_* from then on.
- Bad checksum:
  - Stimulus: start; stream 02,10,20,31.
  - Required: two writes; then error=1, done=0, cpureset stays 1, and cpu_memwrite=1 does not reach mem_memwrite.
- Zero length:
  - Stimulus: start; stream 00,00.
  - Required: no write pulses, done=1, count=0.
- Backpressure and gaps:
  - Stimulus: hold rx_valid=1 with data 05 during WRITE; insert random 0-3 cycle valid gaps.
  - Required: every byte consumed exactly once; rx_ready=0 in WRITE, IDLE and RUN.
- Reset mid-load:
  - Stimulus: reset=0 for one edge after the 2nd data byte of an L=4 load.
  - Required: next cycle IDLE, mem_memwrite=0, cpureset=1, count=0; rx_valid then ignored until start.
- Reload and wrap, BASE=FE:
  - Stimulus: in RUN, start; stream 03,01,02,03,06.
  - Required: cpureset rises on the start edge; writes go to addresses FE, FF, 00; done=1 at the end.

Source files
------------

// File: rtl/boot_loader_if.sv
// rtl/boot_loader_if.sv - byte stream, core bus and memory port bundle for boot_loader
// slave is the loader side; master is whatever drives the stream and the core bus.
interface boot_loader_if #(parameter int WIDTH = 8);
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             cpu_memwrite;
  logic [WIDTH-1:0] cpu_adr;
  logic [WIDTH-1:0] cpu_writedata;
  logic             mem_memwrite;
  logic [WIDTH-1:0] mem_adr;
  logic [WIDTH-1:0] mem_writedata;

  modport slave (
    input  rx_data, rx_valid, cpu_memwrite, cpu_adr, cpu_writedata,
    output rx_ready, mem_memwrite, mem_adr, mem_writedata
  );

  modport master (
    output rx_data, rx_valid, cpu_memwrite, cpu_adr, cpu_writedata,
    input  rx_ready, mem_memwrite, mem_adr, mem_writedata
  );
endinterface

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - loads a length-prefixed, checksummed image into core memory
// The core is held in reset and the memory port is owned here until a load checks out.
module boot_loader #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] BASE  = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  boot_loader_if.slave bus,
  output logic         cpureset,
  output logic         done,
  output logic         error,
  output logic [7:0]   count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_CSUM, S_RUN, S_ERROR
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_len;
  logic [7:0] r_idx;
  logic [7:0] r_sum;
  logic [7:0] r_wbuf;
  logic       w_rx_ready;
  logic       w_xfer;
  logic       w_idle_like;

  // ready comes only from registered state, never from rx_valid
  assign w_rx_ready  = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CSUM);
  assign w_xfer      = w_rx_ready && bus.rx_valid;
  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_RUN) || (r_state == S_ERROR);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_RUN, S_ERROR: if (start) w_next = S_LEN;
      S_LEN:   if (w_xfer) w_next = (bus.rx_data == 8'd0) ? S_CSUM : S_DATA;
      S_DATA:  if (w_xfer) w_next = S_WRITE;
      S_WRITE: w_next = (r_idx + 8'd1 == r_len) ? S_CSUM : S_DATA;
      S_CSUM:  if (w_xfer) w_next = (bus.rx_data == r_sum) ? S_RUN : S_ERROR;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_len  <= 8'd0;
      r_idx  <= 8'd0;
      r_sum  <= 8'd0;
      r_wbuf <= 8'd0;
    end else begin
      if (w_idle_like && start) begin
        r_idx <= 8'd0;
      end
      if (r_state == S_LEN && w_xfer) begin
        r_len <= bus.rx_data;
        r_idx <= 8'd0;
        r_sum <= 8'd0;
      end
      if (r_state == S_DATA && w_xfer) begin
        r_wbuf <= bus.rx_data;
        r_sum  <= r_sum + bus.rx_data;
      end
      if (r_state == S_WRITE) begin
        r_idx <= r_idx + 8'd1;
      end
    end
  end

  assign bus.rx_ready = w_rx_ready;
  assign cpureset     = (r_state != S_RUN);
  assign done         = (r_state == S_RUN);
  assign error        = (r_state == S_ERROR);
  assign count        = r_idx;

  // core owns the memory port only while running
  always_comb begin
    bus.mem_memwrite  = (r_state == S_WRITE);
    bus.mem_adr       = BASE + WIDTH'(r_idx);
    bus.mem_writedata = WIDTH'(r_wbuf);
    if (r_state == S_RUN) begin
      bus.mem_memwrite  = bus.cpu_memwrite;
      bus.mem_adr       = bus.cpu_adr;
      bus.mem_writedata = bus.cpu_writedata;
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - directed vector bench for boot_loader
// Two loaders share one stimulus; the second uses BASE=FE to exercise address wrap.
module tb_boot_loader;
  logic       clk;
  logic       reset;
  logic       start;
  logic       cpureset0, done0, error0;
  logic [7:0] count0;
  logic       cpureset1, done1, error1;
  logic [7:0] count1;

  boot_loader_if #(.WIDTH(8)) bus0 ();
  boot_loader_if #(.WIDTH(8)) bus1 ();

  assign bus1.rx_data       = bus0.rx_data;
  assign bus1.rx_valid      = bus0.rx_valid;
  assign bus1.cpu_memwrite  = bus0.cpu_memwrite;
  assign bus1.cpu_adr       = bus0.cpu_adr;
  assign bus1.cpu_writedata = bus0.cpu_writedata;

  boot_loader #(.WIDTH(8), .BASE(8'h00)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .bus(bus0),
    .cpureset(cpureset0), .done(done0), .error(error0), .count(count0)
  );

  boot_loader #(.WIDTH(8), .BASE(8'hFE)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .bus(bus1),
    .cpureset(cpureset1), .done(done1), .error(error1), .count(count1)
  );

  typedef struct {
    logic [7:0] s[8];
    int         n;
    int         rnd_gap;
    logic       done;
    logic       err;
    logic [7:0] cnt;
    int         nwr;
    logic [7:0] a0[4];
    logic [7:0] a1[4];
    logic [7:0] d[4];
  } vec_t;

  vec_t       tv[5];
  int         n_vec;
  int         n_miss;
  int         n_xfer;
  logic [7:0] wq0_a[$];
  logic [7:0] wq0_d[$];
  logic [7:0] wq1_a[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus0.rx_valid && bus0.rx_ready) n_xfer++;
  end

  always @(negedge clk) begin
    if (bus0.mem_memwrite) begin
      wq0_a.push_back(bus0.mem_adr);
      wq0_d.push_back(bus0.mem_writedata);
    end
    if (bus1.mem_memwrite) wq1_a.push_back(bus1.mem_adr);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one byte (after an optional idle gap) and return just after the edge that takes it.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    if (gap > 0) begin
      bus0.rx_valid = 1'b0;
      repeat (gap) tick();
    end
    bus0.rx_valid = 1'b1;
    bus0.rx_data  = b;
    for (int k = 0; k < 40 && !ok; k++) begin
      if (bus0.rx_ready) ok = 1'b1;
      tick();
    end
    if (!ok) check("rx_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int x0;
    n_vec = 0;
    n_miss = 0;
    n_xfer = 0;

    tv[0] = '{s:'{8'h03, 8'h80, 8'h04, 8'h11, 8'h95, 8'h00, 8'h00, 8'h00}, n:5, rnd_gap:0,
              done:1'b1, err:1'b0, cnt:8'd3, nwr:3,
              a0:'{8'h00, 8'h01, 8'h02, 8'h00}, a1:'{8'hFE, 8'hFF, 8'h00, 8'h00},
              d:'{8'h80, 8'h04, 8'h11, 8'h00}};
    tv[1] = '{s:'{8'h02, 8'h10, 8'h20, 8'h31, 8'h00, 8'h00, 8'h00, 8'h00}, n:4, rnd_gap:0,
              done:1'b0, err:1'b1, cnt:8'd2, nwr:2,
              a0:'{8'h00, 8'h01, 8'h00, 8'h00}, a1:'{8'hFE, 8'hFF, 8'h00, 8'h00},
              d:'{8'h10, 8'h20, 8'h00, 8'h00}};
    tv[2] = '{s:'{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, n:2, rnd_gap:0,
              done:1'b1, err:1'b0, cnt:8'd0, nwr:0,
              a0:'{8'h00, 8'h00, 8'h00, 8'h00}, a1:'{8'h00, 8'h00, 8'h00, 8'h00},
              d:'{8'h00, 8'h00, 8'h00, 8'h00}};
    tv[3] = '{s:'{8'h04, 8'h05, 8'h05, 8'h05, 8'h05, 8'h14, 8'h00, 8'h00}, n:6, rnd_gap:1,
              done:1'b1, err:1'b0, cnt:8'd4, nwr:4,
              a0:'{8'h00, 8'h01, 8'h02, 8'h03}, a1:'{8'hFE, 8'hFF, 8'h00, 8'h01},
              d:'{8'h05, 8'h05, 8'h05, 8'h05}};
    tv[4] = '{s:'{8'h03, 8'h01, 8'h02, 8'h03, 8'h06, 8'h00, 8'h00, 8'h00}, n:5, rnd_gap:1,
              done:1'b1, err:1'b0, cnt:8'd3, nwr:3,
              a0:'{8'h00, 8'h01, 8'h02, 8'h00}, a1:'{8'hFE, 8'hFF, 8'h00, 8'h00},
              d:'{8'h01, 8'h02, 8'h03, 8'h00}};

    reset = 1'b0;
    start = 1'b0;
    bus0.rx_valid = 1'b0;
    bus0.rx_data = 8'h00;
    bus0.cpu_memwrite = 1'b0;
    bus0.cpu_adr = 8'h00;
    bus0.cpu_writedata = 8'h00;
    repeat (3) tick();
    reset = 1'b1;

    check("rst_rx_ready", bus0.rx_ready, 0);
    check("rst_memwrite", bus0.mem_memwrite, 0);
    check("rst_cpureset", cpureset0, 1);
    check("rst_done", done0, 0);
    check("rst_error", error0, 0);
    check("rst_count", count0, 0);
    check("rst_adr0", bus0.mem_adr, 8'h00);
    check("rst_adr1", bus1.mem_adr, 8'hFE);
    check("rst_wdata", bus0.mem_writedata, 8'h00);

    for (int i = 0; i < 5; i++) begin
      wq0_a.delete();
      wq0_d.delete();
      wq1_a.delete();
      x0 = n_xfer;
      pulse_start();
      check($sformatf("v%0d_len_cpureset", i), cpureset0, 1);
      check($sformatf("v%0d_len_done", i), done0, 0);
      check($sformatf("v%0d_len_error", i), error0, 0);
      check($sformatf("v%0d_len_count", i), count0, 0);
      for (int j = 0; j < tv[i].n; j++) begin
        send_byte(tv[i].s[j], tv[i].rnd_gap ? int'($urandom_range(0, 3)) : 0);
        if (j >= 1 && j <= tv[i].n - 2) begin
          check($sformatf("v%0d_b%0d_write_pulse", i, j), bus0.mem_memwrite, 1);
          check($sformatf("v%0d_b%0d_ready_in_write", i, j), bus0.rx_ready, 0);
          check($sformatf("v%0d_b%0d_adr", i, j), bus0.mem_adr, tv[i].a0[j-1]);
          check($sformatf("v%0d_b%0d_wdata", i, j), bus0.mem_writedata, tv[i].d[j-1]);
        end
      end
      bus0.rx_valid = 1'b0;
      check($sformatf("v%0d_done", i), done0, tv[i].done);
      check($sformatf("v%0d_error", i), error0, tv[i].err);
      check($sformatf("v%0d_cpureset", i), cpureset0, !tv[i].done);
      check($sformatf("v%0d_count", i), count0, tv[i].cnt);
      check($sformatf("v%0d_xfers", i), n_xfer - x0, tv[i].n);
      check($sformatf("v%0d_nwrites0", i), wq0_a.size(), tv[i].nwr);
      check($sformatf("v%0d_nwrites1", i), wq1_a.size(), tv[i].nwr);
      for (int k = 0; k < tv[i].nwr && k < wq0_a.size() && k < wq1_a.size(); k++) begin
        check($sformatf("v%0d_w%0d_adr0", i, k), wq0_a[k], tv[i].a0[k]);
        check($sformatf("v%0d_w%0d_adr1", i, k), wq1_a[k], tv[i].a1[k]);
        check($sformatf("v%0d_w%0d_data", i, k), wq0_d[k], tv[i].d[k]);
      end

      x0 = n_xfer;
      bus0.rx_valid = 1'b1;
      bus0.rx_data = 8'h77;
      bus0.cpu_memwrite = 1'b1;
      bus0.cpu_adr = 8'h3C;
      bus0.cpu_writedata = 8'hC3;
      #1;
      check($sformatf("v%0d_post_ready", i), bus0.rx_ready, 0);
      if (tv[i].done) begin
        check($sformatf("v%0d_pass_memwrite", i), bus0.mem_memwrite, 1);
        check($sformatf("v%0d_pass_adr", i), bus0.mem_adr, 8'h3C);
        check($sformatf("v%0d_pass_wdata", i), bus0.mem_writedata, 8'hC3);
      end else begin
        check($sformatf("v%0d_block_memwrite", i), bus0.mem_memwrite, 0);
        check($sformatf("v%0d_block_adr", i), bus0.mem_adr, tv[i].cnt);
      end
      repeat (3) tick();
      check($sformatf("v%0d_post_xfers", i), n_xfer - x0, 0);
      check($sformatf("v%0d_post_cpureset", i), cpureset0, !tv[i].done);
      bus0.rx_valid = 1'b0;
      bus0.cpu_memwrite = 1'b0;
    end

    pulse_start();
    send_byte(8'h04, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    check("mid_write_before_reset", bus0.mem_memwrite, 1);
    bus0.rx_valid = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mid_rst_memwrite", bus0.mem_memwrite, 0);
    check("mid_rst_cpureset", cpureset0, 1);
    check("mid_rst_count", count0, 0);
    check("mid_rst_ready", bus0.rx_ready, 0);
    check("mid_rst_done", done0, 0);
    check("mid_rst_wdata", bus0.mem_writedata, 8'h00);
    x0 = n_xfer;
    bus0.rx_valid = 1'b1;
    bus0.rx_data = 8'h55;
    repeat (4) tick();
    check("mid_rst_ignored", n_xfer - x0, 0);
    start = 1'b1;
    #1;
    check("start_with_byte_ready", bus0.rx_ready, 0);
    tick();
    start = 1'b0;
    check("start_with_byte_xfers", n_xfer - x0, 0);
    check("after_start_ready", bus0.rx_ready, 1);
    tick();
    bus0.rx_valid = 1'b0;
    check("after_start_len_taken", n_xfer - x0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
